// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multicycle MIPS main control unit. Walks each instruction through
//   fetch / decode / execute / memory / writeback. It drives the datapath
//   enables and the 2-bit aluop consumed by the ALU control decoder.
//   Outputs are decoded combinationally from the state register. FETCH also
//   uses mem_ready, and DECODE also uses op.
//
// Parameters
//   MEM_WAIT_EN  1: memory states stall until mem_ready; 0: mem_ready ignored
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   op[5:0]               IR opcode field
//   mem_ready             memory access completes this cycle
//   pcwrite, branch       PC write strobes (pcen = pcwrite | branch & zero)
//   iord, memwrite        memory address select / write strobe
//   irwrite               instruction register load
//   regdst, memtoreg,
//   regwrite              register file write controls
//   alusrca, alusrcb[1:0] ALU operand selects
//   aluop[1:0]            00 add, 01 sub, 10 funct decode (11 never driven)
//   pcsrc[1:0]            00 ALU result, 01 ALUOut, 10 jump target
//   illegal               pulse in DECODE for an unsupported opcode
//   state[3:0]            current state, for debug
module mc_control_fsm #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t cur;
   logic   rdy;

   // With waiting disabled every access is treated as completing at once.
   assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign state = cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH:   cur <= rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur <= S_MEMADR;
                  OP_RTYPE:     cur <= S_RTYPEEX;
                  OP_BEQ:       cur <= S_BEQEX;
                  OP_ADDI:      cur <= S_ADDIEX;
                  OP_J:         cur <= S_JEX;
                  default:      cur <= S_FETCH;
               endcase
            end
            // op is held by the IR, so it still tells lw from sw here.
            S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   cur <= rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   cur <= rdy ? S_FETCH : S_MEMWR;
            S_RTYPEEX: cur <= S_RTYPEWB;
            S_ADDIEX:  cur <= S_ADDIWB;
            default:   cur <= S_FETCH; // WB states, BEQEX, JEX, unused codes
         endcase
      end
   end

   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsrc    = 2'b00;
      illegal  = 1'b0;
      case (cur)
         S_FETCH: begin
            alusrcb = 2'b01;
            // PC and IR load only on the cycle the fetch completes.
            irwrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
               default:                                       illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:  iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

   typedef struct packed {
      logic       pcwrite, branch, iord, memwrite, irwrite;
      logic       regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, aluop, pcsrc;
      logic       illegal;
   } ctl_t;

   typedef struct {
      int         w;    // 0: waiting DUT, 1: MEM_WAIT_EN=0 DUT
      logic [5:0] op;
      logic       rdy;  // mem_ready driven this cycle
      logic [3:0] st;
      ctl_t       ctl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic       mem_ready = 1'b0;
   logic       tie0 = 1'b0;

   logic       pcw0, br0, iord0, mw0, irw0, rd0, m2r0, rw0, asa0, ill0;
   logic [1:0] asb0, aop0, pcs0;
   logic [3:0] st0;
   logic       pcw1, br1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, ill1;
   logic [1:0] asb1, aop1, pcs1;
   logic [3:0] st1;
   ctl_t       o0, o1;

   assign o0 = {pcw0, br0, iord0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, aop0, pcs0, ill0};
   assign o1 = {pcw1, br1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, pcs1, ill1};

   mc_control_fsm u_dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .pcwrite(pcw0), .branch(br0), .iord(iord0), .memwrite(mw0),
      .irwrite(irw0), .regdst(rd0), .memtoreg(m2r0), .regwrite(rw0),
      .alusrca(asa0), .alusrcb(asb0), .aluop(aop0), .pcsrc(pcs0),
      .illegal(ill0), .state(st0)
   );

   mc_control_fsm #(.MEM_WAIT_EN(1'b0)) u_dut_nw (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(tie0),
      .pcwrite(pcw1), .branch(br1), .iord(iord1), .memwrite(mw1),
      .irwrite(irw1), .regdst(rd1), .memtoreg(m2r1), .regwrite(rw1),
      .alusrca(asa1), .alusrcb(asb1), .aluop(aop1), .pcsrc(pcs1),
      .illegal(ill1), .state(st1)
   );

   always #5 clk = ~clk;

   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference control word for a state, straight from the state table.
   function automatic ctl_t ref_ctl(input logic [3:0] s, input logic [5:0] o, input logic r);
      ctl_t c;
      c = '0;
      case (s)
         4'd0:  begin c.alusrcb = 2'b01; c.irwrite = r; c.pcwrite = r; end
         4'd1:  begin
            c.alusrcb = 2'b11;
            c.illegal = !(o inside {6'b100011, 6'b101011, 6'b000000,
                                    6'b000100, 6'b001000, 6'b000010});
         end
         4'd2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
         4'd3:  c.iord = 1;
         4'd4:  begin c.memtoreg = 1; c.regwrite = 1; end
         4'd5:  begin c.iord = 1; c.memwrite = 1; end
         4'd6:  begin c.alusrca = 1; c.aluop = 2'b10; end
         4'd7:  begin c.regdst = 1; c.regwrite = 1; end
         4'd8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; end
         4'd9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
         4'd10: c.regwrite = 1;
         4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
         default: ;
      endcase
      return c;
   endfunction

   task automatic push(input int w, input logic [5:0] o, input logic r, input logic [3:0] s);
      exp_t e;
      e.w = w; e.op = o; e.rdy = r; e.st = s;
      e.ctl = ref_ctl(s, o, (w == 1) ? 1'b1 : r);
      sb.push_back(e);
   endtask

   // Called #1 after a rising edge; plays one expected cycle per entry.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op;
         mem_ready = e.rdy;
         @(negedge clk);
         if (e.w == 0) begin
            chk($sformatf("state[s%0d]", e.st), 32'(st0), 32'(e.st));
            chk($sformatf("ctl[s%0d]", e.st), 32'(o0), 32'(e.ctl));
            chk("aluop!=11", 32'(aop0 == 2'b11), 32'd0);
         end else begin
            chk($sformatf("nw_state[s%0d]", e.st), 32'(st1), 32'(e.st));
            chk($sformatf("nw_ctl[s%0d]", e.st), 32'(o1), 32'(e.ctl));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_run);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: FETCH decode while held in reset.
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(st0), 32'd0);
      chk("rst_ctl", 32'(o0), 32'(ref_ctl(4'd0, 6'd0, 1'b1)));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // lw with two MEMRD stalls; mem_ready low where it must be ignored.
      push(0, 6'b100011, 1, 0); push(0, 6'b100011, 0, 1); push(0, 6'b100011, 0, 2);
      push(0, 6'b100011, 0, 3); push(0, 6'b100011, 0, 3); push(0, 6'b100011, 1, 3);
      push(0, 6'b100011, 0, 4);
      // R-type
      push(0, 6'b000000, 1, 0); push(0, 6'b000000, 1, 1); push(0, 6'b000000, 1, 6);
      push(0, 6'b000000, 1, 7);
      // beq, j
      push(0, 6'b000100, 1, 0); push(0, 6'b000100, 1, 1); push(0, 6'b000100, 1, 8);
      push(0, 6'b000010, 1, 0); push(0, 6'b000010, 1, 1); push(0, 6'b000010, 1, 11);
      // addi with a one-cycle fetch stall
      push(0, 6'b001000, 0, 0); push(0, 6'b001000, 1, 0); push(0, 6'b001000, 1, 1);
      push(0, 6'b001000, 1, 9); push(0, 6'b001000, 1, 10);
      // illegal op
      push(0, 6'b111111, 1, 0); push(0, 6'b111111, 1, 1);
      // sw with one MEMWR stall
      push(0, 6'b101011, 1, 0); push(0, 6'b101011, 1, 1); push(0, 6'b101011, 1, 2);
      push(0, 6'b101011, 0, 5); push(0, 6'b101011, 1, 5);
      // sw again, left stalled in MEMWR for the reset check
      push(0, 6'b101011, 1, 0); push(0, 6'b101011, 1, 1); push(0, 6'b101011, 1, 2);
      push(0, 6'b101011, 0, 5);
      drain();

      // Now mid-cycle after the rising edge, still in MEMWR with memwrite high.
      chk("pre_rst_memwrite", 32'(mw0), 32'd1);
      mem_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(st0), 32'd0);
      chk("async_rst_memwrite", 32'(mw0), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(0, 6'b000000, 1, 0); push(0, 6'b000000, 1, 1); push(0, 6'b000000, 1, 6);
      push(0, 6'b000000, 1, 7); push(0, 6'b000000, 1, 0);
      drain();

      // MEM_WAIT_EN=0 instance, mem_ready tied low: sw must not stall.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(1, 6'b101011, 0, 0); push(1, 6'b101011, 0, 1); push(1, 6'b101011, 0, 2);
      push(1, 6'b101011, 0, 5); push(1, 6'b101011, 0, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main control unit for the MIPS core; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables, including the 2-bit aluop consumed by the ALU control decoder.
- Encoding of aluop: 00 = add, 01 = subtract, 10 = decode funct field. This block never emits 11.

Parameters:
- MEM_WAIT_EN, default 1: when 1, memory-access states stall until mem_ready is high; when 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode field of the instruction register (instr[31:26])
- mem_ready  in  1  unified memory has completed the current access this cycle
- pcwrite  out  1  unconditional PC write
- branch  out  1  conditional PC write; external logic forms pcen = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- aluop  out  2  to ALU control
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse in DECODE when op is unsupported
- state  out  4  current state encoding, for debug

Behaviour:
- State register: 4 bits, async reset to FETCH. Outputs are decoded combinationally from state (plus mem_ready where noted).
- During and immediately after reset, outputs equal the FETCH decode. Any output not listed for a state is 0.
- State encodings and outputs:
  - FETCH = 0: alusrcb = 01, aluop = 00, irwrite = mem_ready, pcwrite = mem_ready.
  - DECODE = 1: alusrcb = 11, aluop = 00. illegal = 1 if op is unsupported.
  - MEMADR = 2: alusrca = 1, alusrcb = 10, aluop = 00.
  - MEMRD = 3: iord = 1.
  - MEMWB = 4: memtoreg = 1, regwrite = 1.
  - MEMWR = 5: iord = 1, memwrite = 1.
  - RTYPEEX = 6: alusrca = 1, alusrcb = 00, aluop = 10.
  - RTYPEWB = 7: regdst = 1, regwrite = 1.
  - BEQEX = 8: alusrca = 1, aluop = 01, pcsrc = 01, branch = 1.
  - ADDIEX = 9: alusrca = 1, alusrcb = 10, aluop = 00.
  - ADDIWB = 10: regwrite = 1.
  - JEX = 11: pcsrc = 10, pcwrite = 1.
- Encodings 12–15 are unreachable; if entered, outputs are all 0 and the next state is FETCH.
- Transitions:
  - FETCH -> DECODE when mem_ready, else stay in FETCH.
  - DECODE, by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other op -> FETCH
  - MEMADR -> MEMRD for lw, MEMWR for sw. op is held stable by the IR.
  - MEMRD -> MEMWB when mem_ready, else stay.
  - MEMWR -> FETCH when mem_ready, else stay. memwrite stays high throughout the stall.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
  - RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
- Latency in cycles, with mem_ready always 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal op 2.
  - Each stall cycle adds 1.
- Stall semantics:
  - irwrite and pcwrite in FETCH are gated by mem_ready, so the IR and PC update exactly once, on the completing cycle.
  - Other outputs are held stable while stalled.
- Reset asserted mid-instruction: state forces to FETCH asynchronously and all strobes drop immediately; no partial write completes after the rst_n falling edge.
- Simultaneous events: mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.

Test Plan:
- Reset: rst_n = 0 mid-MEMWR with memwrite = 1 -> state = 0 and memwrite = 0 in the same cycle. After release with mem_ready = 1 -> irwrite = 1, pcwrite = 1, alusrcb = 01, aluop = 00.
- lw with mem_ready low for 2 cycles in MEMRD -> state sequence 0, 1, 2, 3, 3, 3, 4, 0. regwrite = 1 and memtoreg = 1 only in state 4. Total 7 cycles.
- R-type (op = 000000) -> aluop = 10 with alusrca = 1, alusrcb = 00 in state 6. State 7 has regdst = 1, regwrite = 1. Back to FETCH after 4 cycles.
- beq (op = 000100) -> state 8 has aluop = 01, branch = 1, pcsrc = 01, pcwrite = 0. Returns to state 0 next cycle.
- sw with MEM_WAIT_EN = 0 and mem_ready tied 0 -> sequence 0, 1, 2, 5, 0 with no stall. memwrite = 1 for exactly 1 cycle; iord = 1 in state 5.
- Illegal op = 111111 -> illegal = 1 for one cycle in DECODE, next state FETCH. No regwrite, memwrite or pcwrite asserted outside FETCH. aluop never equals 11 in any state.
